// File: rtl/text_buffer_pkg.sv
// rtl/text_buffer_pkg.sv - shared constants, FSM states and address helpers for the text buffer
package text_buffer_pkg;

    localparam int DEF_H_DISP = 1280;
    localparam int DEF_V_DISP = 1024;
    localparam int DEF_CHAR_W = 8;
    localparam int DEF_CHAR_H = 8;
    localparam int DEF_ATTR_W = 8;
    localparam logic [7:0] DEF_FILL_ATTR = 8'h07;
    localparam logic [7:0] FILL_CHAR = 8'h20;

    localparam int DEF_COLS   = DEF_H_DISP / DEF_CHAR_W;
    localparam int DEF_ROWS   = DEF_V_DISP / DEF_CHAR_H;
    localparam int DEF_ROW_W  = $clog2(DEF_ROWS);
    localparam int DEF_COL_W  = $clog2(DEF_COLS);
    localparam int DEF_ADDR_W = $clog2(DEF_ROWS * DEF_COLS);
    localparam int DEF_DATA_W = DEF_ATTR_W + 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL
    } state_t;

    // Ring-buffer wrap without a divider: row and top are both below rows.
    function automatic int unsigned phys_row(input int unsigned row, input int unsigned top,
                                             input int unsigned rows);
        int unsigned sum;
        sum = row + top;
        return (sum >= rows) ? sum - rows : sum;
    endfunction

    function automatic int unsigned cell_addr(input int unsigned row, input int unsigned col,
                                              input int unsigned top, input int unsigned rows,
                                              input int unsigned cols);
        return phys_row(row, top, rows) * cols + col;
    endfunction

    function automatic logic [63:0] fill_word(input logic [55:0] attr);
        return {attr, FILL_CHAR};
    endfunction

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - simple dual-port RAM: write port A, registered read port B
module text_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle read of a cell being written returns the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - row/column text buffer with write handshake, ring-buffer scroll and clear engine
module text_buffer_ctrl
    import text_buffer_pkg::*;
#(
    parameter int H_DISP = DEF_H_DISP,
    parameter int V_DISP = DEF_V_DISP,
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int CHAR_H = DEF_CHAR_H,
    parameter int ATTR_W = DEF_ATTR_W,
    parameter logic [ATTR_W-1:0] FILL_ATTR = ATTR_W'(DEF_FILL_ATTR),
    localparam int COLS   = H_DISP / CHAR_W,
    localparam int ROWS   = V_DISP / CHAR_H,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int COL_W  = $clog2(COLS),
    localparam int ADDR_W = $clog2(ROWS * COLS),
    localparam int DATA_W = ATTR_W + 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              cmd_clear,
    input  logic              cmd_scroll,
    output logic              cmd_ready,
    output logic              busy,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic [ROW_W-1:0]  top_row
);

    localparam int CELLS = ROWS * COLS;
    localparam logic [DATA_W-1:0] FILL = DATA_W'(fill_word(56'(FILL_ATTR)));

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ROW_W-1:0]  top_q, top_d;
    logic [ROW_W-1:0]  top_inc;
    logic              wr_err_q, wr_err_d;
    logic              idle;

    logic              wr_in_range;
    logic              rd_in_range;
    logic [ADDR_W-1:0] wr_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_oor_q;

    assign wr_in_range = (32'(wr_row) < 32'(ROWS)) && (32'(wr_col) < 32'(COLS));
    assign rd_in_range = (32'(rd_row) < 32'(ROWS)) && (32'(rd_col) < 32'(COLS));
    assign wr_addr     = ADDR_W'(cell_addr(32'(wr_row), 32'(wr_col), 32'(top_q), ROWS, COLS));
    assign ram_raddr   = rd_in_range ?
                         ADDR_W'(cell_addr(32'(rd_row), 32'(rd_col), 32'(top_q), ROWS, COLS)) : '0;
    assign top_inc     = (32'(top_q) == 32'(ROWS - 1)) ? '0 : top_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        top_d     = top_q;
        wr_err_d  = 1'b0;
        idle      = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        case (state_q)
            IDLE: begin
                idle = 1'b1;
                // The write uses the pre-command mapping; the command starts next cycle.
                if (wr_valid) begin
                    ram_we   = wr_in_range;
                    wr_err_d = !wr_in_range;
                end
                if (cmd_clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    top_d   = '0;
                end else if (cmd_scroll) begin
                    state_d = SCROLL;
                    cnt_d   = '0;
                    base_d  = ADDR_W'(32'(top_q) * 32'(COLS));
                    top_d   = top_inc;
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = FILL;
                if (32'(cnt_q) == 32'(CELLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SCROLL: begin
                // Blank the row that just left the top; it is now the bottom logical row.
                ram_we    = 1'b1;
                ram_waddr = base_q + cnt_q;
                ram_wdata = FILL;
                if (32'(cnt_q) == 32'(COLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                top_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            base_q   <= '0;
            top_q    <= '0;
            wr_err_q <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            top_q    <= top_d;
            wr_err_q <= wr_err_d;
            rd_oor_q <= !rd_in_range;
        end
    end

    text_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (CELLS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign wr_ready  = idle;
    assign cmd_ready = idle;
    assign busy      = !idle;
    assign wr_err    = wr_err_q;
    assign top_row   = top_q;
    assign rd_data   = rd_oor_q ? FILL : ram_rdata;

endmodule
